btn_edge_conditioner: RTL

Parametrised, multi-channel button front end for the calculator's push-button inputs. It replaces the bare single-bit rising-edge detector with a per-channel pipeline of synchronizer, debounce counter, selectable edge detector and optional auto-repeat. It sits between the Basys3 button pins and the calculator control FSM, which consumes only the one-cycle `pulse_out` strobes and the clean `level_out` levels.

---
 rtl/btn_cond_pkg.sv | 19 +
 rtl/btn_channel.sv | 90 +++++++++
 rtl/btn_edge_conditioner.sv | 54 +++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// Shared edge-mode encodings and counter sizing helpers for the button conditioner.
// Pure definitions: no latency or backpressure of its own.
package btn_cond_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    // Bits needed for a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: synchronizer, debounce, mode-selected edge strobe and auto-repeat.
// level_o and pulse_o move SYNC_STAGES+DEBOUNCE_CYCLES cycles after a stable input change; strobes are never stalled.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_i,
    input  logic [1:0] edge_mode_i,
    input  logic       repeat_en_i,
    output logic       pulse_o,
    output logic       level_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   phase_q, phase_d;

    logic s;
    logic settle;
    logic rise, fall;
    logic rise_en, fall_en;
    logic rep_run, rep_hit;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise_en = (edge_mode_i == EDGE_RISE) || (edge_mode_i == EDGE_BOTH);
    assign fall_en = (edge_mode_i == EDGE_FALL) || (edge_mode_i == EDGE_BOTH);

    always_comb begin
        settle  = (s != level_q) && (cnt_q == DB_LAST);
        rise    = settle && s;
        fall    = settle && !s;
        level_d = settle ? s : level_q;
        cnt_d   = ((s == level_q) || settle) ? '0 : cnt_q + CW'(1);

        // phase_q selects the first-tick delay versus the steady repeat period;
        // reloading to zero on every tick keeps the spacing exact.
        rep_run = level_q && repeat_en_i && rise_en;
        rep_hit = rep_run && (rcnt_q == (phase_q ? RR_LAST : RD_LAST));
        rcnt_d  = rcnt_q + RW'(1);
        phase_d = phase_q;
        if (!rep_run) begin
            rcnt_d  = '0;
            phase_d = 1'b0;
        end else if (rep_hit) begin
            rcnt_d  = '0;
            phase_d = 1'b1;
        end

        // A tick coinciding with a fall is dropped; in both-edge mode the fall itself still strobes.
        pulse_d = (rise && rise_en) || (fall && fall_en) || (rep_hit && !fall);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            phase_q <= phase_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_edge_conditioner.sv
// Multi-channel push-button front end: per-channel sync, debounce, edge strobe and auto-repeat.
// Outputs lag a stable press by SYNC_STAGES+DEBOUNCE_CYCLES cycles; strobes are one-cycle and never stalled.
module btn_edge_conditioner
    import btn_cond_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_in,
    input  logic [1:0]          edge_mode,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] level_out
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("btn_edge_conditioner: CHANNELS must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_edge_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_edge_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("btn_edge_conditioner: REPEAT_DELAY must be at least 1");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("btn_edge_conditioner: REPEAT_RATE must be at least 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_i       (btn_in[i]),
            .edge_mode_i (edge_mode),
            .repeat_en_i (repeat_en),
            .pulse_o     (pulse_out[i]),
            .level_o     (level_out[i])
        );
    end

endmodule
